// File: rtl/dataout_reader.sv
// rtl/dataout_reader.sv - dataout port consumer: credit-gated read strobes feeding a small output FIFO
module dataout_reader #(
  parameter int BW    = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ready,
  output logic                     read,
  input  logic [BW-1:0]            data_out,
  input  logic                     enable,
  output logic                     out_valid,
  output logic [BW-1:0]            out_data,
  input  logic                     out_accept,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CW-1:0]            rd_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic          inflight;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [BW-1:0] mem [DEPTH];
  logic          push;
  logic          pop;
  logic [LW:0]   committed;
  logic [LW-1:0] level_next;

  assign push = inflight;
  assign pop  = out_valid & out_accept;

  // Slots already owed: stored bytes, the byte on data_out now, and the byte strobed this cycle.
  assign committed = (LW+1)'(level) + (LW+1)'(inflight) + (LW+1)'(read);

  assign out_data = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LW'(1);
    end else if (pop && !push) begin
      level_next = level - LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read      <= 1'b0;
      inflight  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      rd_count  <= '0;
    end else begin
      read     <= enable & ready & (committed < (LW+1)'(DEPTH));
      inflight <= read;
      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        rd_count <= rd_count + CW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level     <= level_next;
      out_valid <= (level_next != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= data_out;
    end
  end

  // The credit rule must make a push into a full FIFO without a pop impossible.
  assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (level == LW'(DEPTH))));

endmodule

// File: tb/tb_dataout_reader.sv
// tb/tb_dataout_reader.sv - randomized and directed bench for dataout_reader against a queue model
module tb_dataout_reader;
  localparam int BW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   ready = 1'b0;
  logic                   read;
  logic [BW-1:0]          data_out = '0;
  logic                   enable = 1'b0;
  logic                   out_valid;
  logic [BW-1:0]          out_data;
  logic                   out_accept = 1'b0;
  logic [$clog2(DEPTH):0] level;
  logic [CW-1:0]          rd_count;

  dataout_reader #(.BW(BW), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .ready(ready), .read(read), .data_out(data_out),
    .enable(enable), .out_valid(out_valid), .out_data(out_data),
    .out_accept(out_accept), .level(level), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: FIFO contents as a queue, plus the two outstanding strobes.
  logic [7:0]    m_q[$];
  bit            m_read = 0;
  bit            m_inflight = 0;
  logic [CW-1:0] m_count = '0;

  // Source side and observed output stream.
  logic [7:0] src_q[$];
  logic [7:0] sent_q[$];
  logic [7:0] got_q[$];
  int         src_avail = 0;
  bit         auto_ready = 0;
  bit         ready_rand = 0;
  bit         read_d = 0;
  int         strobes = 0;
  int         max_level = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit do_pop;
    bit nr;
    if (rst) begin
      m_q.delete();
      m_read = 0;
      m_inflight = 0;
      m_count = '0;
    end else begin
      do_pop = (m_q.size() != 0) && out_accept;
      nr = enable && ready && ((m_q.size() + int'(m_inflight) + int'(m_read)) < DEPTH);
      if (do_pop) void'(m_q.pop_front());
      if (m_inflight) begin
        check("model_no_overflow", 32'(m_q.size() < DEPTH), 32'd1);
        m_q.push_back(data_out);
        m_count = m_count + 1'b1;
      end
      m_inflight = m_read;
      m_read = nr;
    end
  endtask

  task automatic compare();
    check("read", 32'(read), 32'(m_read));
    check("out_valid", 32'(out_valid), 32'(m_q.size() != 0));
    check("out_data", 32'(out_data), (m_q.size() != 0) ? 32'(m_q[0]) : 32'd0);
    check("level", 32'(level), 32'(m_q.size()));
    check("rd_count", 32'(rd_count), 32'(m_count));
  endtask

  task automatic cycle();
    if (out_valid && out_accept) got_q.push_back(out_data);
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (int'(level) > max_level) max_level = int'(level);
    if (read) begin
      strobes++;
      if (src_avail > 0) src_avail--;
    end
    if (read_d && src_q.size() != 0) data_out = src_q.pop_front();
    else data_out = 8'($urandom);
    read_d = read;
    if (auto_ready) ready = (src_avail > 0) && (!ready_rand || $urandom_range(3) != 0);
  endtask

  task automatic do_reset();
    rst = 1; enable = 0; ready = 0; out_accept = 0; auto_ready = 0; ready_rand = 0;
    cycle();
    rst = 0;
    src_q.delete(); sent_q.delete(); got_q.delete();
    src_avail = 0; strobes = 0; max_level = 0;
  endtask

  task automatic load(input logic [7:0] b);
    src_q.push_back(b);
    sent_q.push_back(b);
    src_avail++;
  endtask

  initial begin
    int bad;
    bit [3:0] pat;

    // Reset state
    do_reset();
    check("rst_read", 32'(read), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_rd_count", 32'(rd_count), 32'd0);

    // Full-throughput stream 0x01..0x10
    for (int i = 1; i <= 16; i++) load(8'(i));
    auto_ready = 1; enable = 1; out_accept = 1; ready = 1;
    for (int i = 0; i < 60 && got_q.size() < 16; i++) cycle();
    check("stream_count", 32'(got_q.size()), 32'd16);
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] != 8'(i + 1)) bad++;
    check("stream_order", 32'(bad), 32'd0);
    check("stream_rd_count", 32'(rd_count), 32'd16);
    check("stream_strobes", 32'(strobes), 32'd16);
    check("stream_max_level_le2", 32'(max_level <= 2), 32'd1);

    // Backpressure
    do_reset();
    for (int i = 0; i < 8; i++) load(8'hA0 + 8'(i));
    auto_ready = 1; enable = 1; ready = 1; out_accept = 0;
    for (int i = 0; i < 10; i++) cycle();
    check("bp_strobes", 32'(strobes), 32'd4);
    check("bp_level", 32'(level), 32'd4);
    check("bp_head", 32'(out_data), 32'hA0);
    out_accept = 1;
    cycle();
    out_accept = 0;
    for (int i = 0; i < 6; i++) cycle();
    check("bp_strobes_after_pop", 32'(strobes), 32'd5);
    check("bp_level_refill", 32'(level), 32'd4);
    check("bp_head_after_pop", 32'(out_data), 32'hA1);
    enable = 0; out_accept = 1;
    for (int i = 0; i < 8; i++) cycle();
    check("bp_drain_count", 32'(got_q.size()), 32'd5);
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] != 8'hA0 + 8'(i)) bad++;
    check("bp_drain_order", 32'(bad), 32'd0);

    // ready toggling 1,0,1,0
    do_reset();
    load(8'h55); load(8'h66);
    enable = 1; out_accept = 1;
    ready = 1; cycle(); pat[3] = read;
    ready = 0; cycle(); pat[2] = read;
    ready = 1; cycle(); pat[1] = read;
    ready = 0; cycle(); pat[0] = read;
    for (int i = 0; i < 6; i++) cycle();
    check("toggle_pattern", 32'(pat), 32'b1010);
    check("toggle_strobes", 32'(strobes), 32'd2);
    check("toggle_count", 32'(got_q.size()), 32'd2);
    check("toggle_byte0", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h55);
    check("toggle_byte1", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hDEAD, 32'h66);
    check("toggle_rd_count", 32'(rd_count), 32'd2);

    // Reset the cycle after a strobe
    do_reset();
    load(8'h77);
    auto_ready = 1; enable = 1; ready = 1; out_accept = 1;
    for (int i = 0; i < 10 && !read; i++) cycle();
    check("rstmid_strobe_seen", 32'(read), 32'd1);
    enable = 0;
    cycle();
    do_reset();
    for (int i = 0; i < 4; i++) cycle();
    check("rstmid_level", 32'(level), 32'd0);
    check("rstmid_rd_count", 32'(rd_count), 32'd0);
    check("rstmid_read", 32'(read), 32'd0);
    check("rstmid_out_valid", 32'(out_valid), 32'd0);

    // enable dropped while read=1
    do_reset();
    load(8'h3C); load(8'h3D); load(8'h3E);
    auto_ready = 1; enable = 1; ready = 1; out_accept = 1;
    for (int i = 0; i < 10 && !read; i++) cycle();
    check("endrop_strobe_seen", 32'(read), 32'd1);
    enable = 0;
    for (int i = 0; i < 6; i++) cycle();
    check("endrop_strobes", 32'(strobes), 32'd1);
    check("endrop_rd_count", 32'(rd_count), 32'd1);
    check("endrop_count", 32'(got_q.size()), 32'd1);
    check("endrop_byte", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h3C);

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 2000; i++) load(8'($urandom));
    auto_ready = 1; ready_rand = 1; ready = 1;
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(7) != 0);
      out_accept = 1'($urandom_range(1));
      cycle();
    end
    check("rand_progress", 32'(got_q.size() > 200), 32'd1);
    bad = 0;
    for (int i = 0; i < got_q.size(); i++) if (got_q[i] != sent_q[i]) bad++;
    check("rand_order", 32'(bad), 32'd0);
    check("rand_max_level", 32'(max_level <= DEPTH), 32'd1);

    // rd_count wrap at 2^CW
    do_reset();
    for (int i = 0; i < 65535; i++) load(8'(i));
    auto_ready = 1; enable = 1; ready = 1; out_accept = 1;
    for (int i = 0; i < 70000 && got_q.size() < 65535; i++) cycle();
    for (int i = 0; i < 3; i++) cycle();
    check("wrap_pre_count", 32'(got_q.size()), 32'd65535);
    check("wrap_pre_rd_count", 32'(rd_count), 32'hFFFF);
    load(8'h5A);
    ready = 1;
    for (int i = 0; i < 10 && got_q.size() < 65536; i++) cycle();
    check("wrap_rd_count", 32'(rd_count), 32'h0000);
    check("wrap_last_byte", (got_q.size() == 65536) ? 32'(got_q[65535]) : 32'hDEAD, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/dataout_reader.md
Name: dataout_reader

Overview:
- Consumer end of the dataout ready/read/data_out port.
- Requests bytes with a one-cycle `read` strobe while the source raises `ready`, and captures `data_out` one cycle after each strobe.
- Buffers captured bytes in a small FIFO and presents them downstream on a valid/accept stream.
- Used as the RTL sink that the dataout agent's driver (source model) exercises.

Parameters:
- BW, 8, data width of data_out and out_data
- DEPTH, 4, FIFO entries (power of two, 2..16)
- CW, 16, width of the captured-byte counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- ready  input  1  source has at least one byte available
- read  output  1  read strobe, one byte per high cycle
- data_out  input  BW  source data, valid the cycle after read
- enable  input  1  permits new read strobes
- out_valid  output  1  FIFO head is valid
- out_data  output  BW  FIFO head byte
- out_accept  input  1  downstream takes the head byte
- level  output  $clog2(DEPTH)+1  FIFO occupancy
- rd_count  output  CW  total bytes captured

Behaviour:
- Reset: one clk cycle with rst=1 sets read=0, out_valid=0, out_data=0, level=0, rd_count=0, FIFO pointers=0, inflight=0.
- Reset mid-transfer: a byte whose read strobe came before or during reset is discarded.
- Clock/reset: single clock domain; all outputs are registered except out_data, which is a combinational head-of-FIFO read.
- Read protocol: read is registered.
  - read(next) = enable & ready & ~rst & (level + inflight + read < DEPTH).
  - inflight is the registered copy of read, i.e. read from the previous cycle.
  - Strobes may be back-to-back: one byte per cycle at full throughput.
  - The source must hold ready only while it has data. The reader trusts ready sampled in the same cycle the strobe decision is made.
- Capture: in the cycle after read=1, data_out is pushed into the FIFO and rd_count increments.
  - rd_count wraps modulo 2^CW without a flag.
- Credit rule: a strobe is issued only if a free slot is guaranteed for every byte not yet pushed. This counts the registered read and inflight against level.
  - The FIFO therefore never overflows.
  - An overflow would be a design bug; a simulation assertion on it is required.
- Output stream:
  - out_valid = (level != 0).
  - out_data = FIFO head.
  - A pop occurs when out_valid & out_accept.
  - out_data is stable while out_valid=1 and out_accept=0.
- Simultaneous push and pop: level is unchanged, and the head advances to the next entry.
  - Allowed at any level, including DEPTH and 1.
  - A push into an empty FIFO makes out_valid=1 the next cycle. There is no bypass; latency from read strobe to out_valid is 2 cycles.
- Full: level=DEPTH keeps read low. Strobing resumes the cycle after a pop makes room.
- Empty: out_valid=0. out_accept is ignored, with no underflow and no pointer movement.
- enable deassert: no new strobes from the next cycle. A strobe already issued still completes its capture.
- ready drop: read goes low the cycle after ready is sampled low. No byte is lost.
- FIFO pointers wrap modulo DEPTH.
- level ranges 0..DEPTH.

Test Plan:
- Reset, then enable=1, ready=1, out_accept=1, source sending 0x01..0x10 → read high every cycle after the first; out_data sequence 0x01..0x10 in order; rd_count=16; level ≤ 2.
- Backpressure: out_accept=0, source sending 0xA0.. → exactly 4 strobes; level=4; out_data=0xA0 held. Then out_accept=1 for 1 cycle → one more strobe; 0xA4 lands at the tail.
- ready toggling 1,0,1,0 with data 0x55,0x66 → two strobes, each one cycle after ready=1 is sampled; bytes captured = {0x55,0x66}; no spurious capture.
- rst asserted the cycle right after a strobe → the byte presented next cycle is not stored; level=0, rd_count=0, read=0.
- enable dropped while read=1 → that byte (0x3C) is still captured; no further strobes while ready stays 1; rd_count +1 only.
- Preload rd_count to 0xFFFF, then capture one byte → rd_count=0x0000, data delivered normally.
